inst_loader: RTL and testbench

- UART program loader that sits directly upstream of the instruction fetch stage.
- Receives a length-prefixed program image over a serial line and writes each 32-bit word into the instruction BRAM write port (addra/dina/wea).
- Signals completion so the system can move to STALL, where fetch copies the BRAM into its distributed instruction memory.
- Active only while mode == LOAD.

---
 rtl/inst_loader.sv | 231 +++++++++++++++++++++++
 tb/tb_inst_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// UART program loader: receives a length-prefixed, big-endian image over 8N1 serial
// and writes each 32-bit word into the instruction BRAM write port while mode is LOAD.
module inst_loader #(
  parameter int CLK_PER_HALF_BIT = 434,
  parameter int INST_SIZE        = 14
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [2:0]           mode,
  input  logic                 rxd,
  output logic [INST_SIZE-1:0] bram_addr,
  output logic [31:0]          bram_din,
  output logic                 bram_we,
  output logic [INST_SIZE:0]   loaded_words,
  output logic                 done,
  output logic                 err
);

  localparam logic [2:0]  MODE_LOAD = 3'd1;
  localparam int          CW        = $clog2(2 * CLK_PER_HALF_BIT + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_HALF_BIT - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(2 * CLK_PER_HALF_BIT - 1);
  localparam logic [31:0] CAPACITY  = 32'd1 << INST_SIZE;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HI} rx_state_e;
  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_BODY, S_DONE} ld_state_e;

  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e            rx_state_q, rx_state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [7:0]           rx_byte_q, rx_byte_d;
  logic                 byte_valid_q, byte_valid_d;
  logic                 frame_err_s;
  ld_state_e            ld_state_q, ld_state_d;
  logic [1:0]           byte_cnt_q, byte_cnt_d;
  logic [31:0]          asm_q, asm_d;
  logic [INST_SIZE:0]   len_q, len_d;
  logic [INST_SIZE-1:0] bram_addr_q, bram_addr_d;
  logic [31:0]          bram_din_q, bram_din_d;
  logic                 bram_we_q, bram_we_d;
  logic [INST_SIZE:0]   loaded_q, loaded_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [31:0]          word_s;
  logic                 accept_s;

  // State registers, including the reset-to-idle-high rxd synchronizer
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= 3'd0;
      rx_byte_q    <= 8'd0;
      byte_valid_q <= 1'b0;
      ld_state_q   <= S_IDLE;
      byte_cnt_q   <= 2'd0;
      asm_q        <= 32'd0;
      len_q        <= '0;
      bram_addr_q  <= '0;
      bram_din_q   <= 32'd0;
      bram_we_q    <= 1'b0;
      loaded_q     <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      rx_meta_q    <= rxd;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      rx_state_q   <= rx_state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      rx_byte_q    <= rx_byte_d;
      byte_valid_q <= byte_valid_d;
      ld_state_q   <= ld_state_d;
      byte_cnt_q   <= byte_cnt_d;
      asm_q        <= asm_d;
      len_q        <= len_d;
      bram_addr_q  <= bram_addr_d;
      bram_din_q   <= bram_din_d;
      bram_we_q    <= bram_we_d;
      loaded_q     <= loaded_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // UART receiver: samples mid-bit, LSB first; a low stop bit waits for idle-high before rearming
  always_comb begin
    rx_state_d   = rx_state_q;
    cnt_d        = cnt_q + CW'(1);
    bit_idx_d    = bit_idx_q;
    rx_byte_d    = rx_byte_q;
    byte_valid_d = 1'b0;
    frame_err_s  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
        else                         rx_state_d = RX_IDLE;
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          if (rx_sync_q) rx_state_d = RX_IDLE;
          else           rx_state_d = RX_DATA;
        end else begin
          rx_state_d = RX_START;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d     = '0;
          rx_byte_d = {rx_sync_q, rx_byte_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
          else                   rx_state_d = RX_DATA;
        end else begin
          rx_state_d = RX_DATA;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d = '0;
          if (rx_sync_q) begin
            byte_valid_d = 1'b1;
            rx_state_d   = RX_IDLE;
          end else begin
            frame_err_s = 1'b1;
            rx_state_d  = RX_WAIT_HI;
          end
        end else begin
          rx_state_d = RX_STOP;
        end
      end
      RX_WAIT_HI: begin
        cnt_d = '0;
        if (rx_sync_q) rx_state_d = RX_IDLE;
        else           rx_state_d = RX_WAIT_HI;
      end
      default: begin
        cnt_d      = '0;
        rx_state_d = RX_IDLE;
      end
    endcase
  end

  assign word_s   = {asm_q[23:0], rx_byte_q};
  assign accept_s = byte_valid_q && (mode == MODE_LOAD);

  // Loader FSM: everything freezes in HEADER/BODY while mode is not LOAD
  always_comb begin
    ld_state_d  = ld_state_q;
    byte_cnt_d  = byte_cnt_q;
    asm_d       = asm_q;
    len_d       = len_q;
    bram_addr_d = bram_addr_q;
    bram_din_d  = bram_din_q;
    bram_we_d   = 1'b0;
    loaded_d    = loaded_q;
    err_d       = err_q | frame_err_s;
    case (ld_state_q)
      S_IDLE: begin
        if (mode == MODE_LOAD) ld_state_d = S_HEADER;
        else                   ld_state_d = S_IDLE;
      end
      S_HEADER: begin
        if (accept_s) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          asm_d      = word_s;
          if (byte_cnt_q == 2'd3) begin
            asm_d = 32'd0;
            if (word_s == 32'd0) begin
              ld_state_d = S_DONE;
            end else if (word_s > CAPACITY) begin
              err_d      = 1'b1;
              ld_state_d = S_DONE;
            end else begin
              len_d      = word_s[INST_SIZE:0];
              ld_state_d = S_BODY;
            end
          end else begin
            ld_state_d = S_HEADER;
          end
        end else begin
          ld_state_d = S_HEADER;
        end
      end
      S_BODY: begin
        if (mode != MODE_LOAD) begin
          ld_state_d = S_BODY;
        end else if (loaded_q == len_q) begin
          ld_state_d = S_DONE;
        end else if (byte_valid_q) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          asm_d      = word_s;
          if (byte_cnt_q == 2'd3) begin
            asm_d       = 32'd0;
            bram_we_d   = 1'b1;
            bram_addr_d = loaded_q[INST_SIZE-1:0];
            bram_din_d  = word_s;
            loaded_d    = loaded_q + (INST_SIZE+1)'(1);
          end else begin
            bram_we_d = 1'b0;
          end
        end else begin
          ld_state_d = S_BODY;
        end
      end
      S_DONE: begin
        ld_state_d = S_DONE;
      end
      default: begin
        ld_state_d = S_IDLE;
      end
    endcase
    done_d = (ld_state_d == S_DONE);
  end

  assign bram_addr    = bram_addr_q;
  assign bram_din     = bram_din_q;
  assign bram_we      = bram_we_q;
  assign loaded_words = loaded_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_inst_loader.sv
// Randomized bench for inst_loader: a byte-level model derives the expected writes,
// length handling and flags from the accepted serial bytes.
module tb_inst_loader;
  localparam int HALF = 4;
  localparam int ISZ  = 4;
  localparam int CAP  = 1 << ISZ;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic [2:0]     mode = 3'd0;
  logic           rxd = 1'b1;
  logic [ISZ-1:0] bram_addr;
  logic [31:0]    bram_din;
  logic           bram_we;
  logic [ISZ:0]   loaded_words;
  logic           done;
  logic           err;

  int checks = 0;
  int failures = 0;
  logic [7:0]  mq[$];
  logic [35:0] wq[$];
  int cyc = 0;
  int last_we_cyc = -1;
  int done_cyc = -1;
  bit mon_rst = 1'b0;
  bit ferr = 1'b0;

  inst_loader #(.CLK_PER_HALF_BIT(HALF), .INST_SIZE(ISZ)) dut (
    .clk(clk), .rstn(rstn), .mode(mode), .rxd(rxd),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_we(bram_we),
    .loaded_words(loaded_words), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Capture every write pulse and the first cycle done is seen
  always begin
    @(posedge clk);
    mon_rst = !rstn;
    #1;
    cyc++;
    if (mon_rst) begin
      wq.delete();
      last_we_cyc = -1;
      done_cyc = -1;
    end else begin
      if (bram_we) begin
        wq.push_back({bram_addr, bram_din});
        last_we_cyc = cyc;
      end
      if (done && done_cyc < 0) done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good);
    if (good && mode == 3'd1) mq.push_back(b);
    if (!good) ferr = 1'b1;
    rxd = 1'b0;
    hold(2 * HALF);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      hold(2 * HALF);
    end
    rxd = good;
    hold(2 * HALF);
    rxd = 1'b1;
    hold(2 * HALF);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24], 1'b1);
    send_byte(w[23:16], 1'b1);
    send_byte(w[15:8], 1'b1);
    send_byte(w[7:0], 1'b1);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    hold(2);
    rstn = 1'b1;
    mq.delete();
    ferr = 1'b0;
    hold(1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"}, 64'(bram_addr), 64'd0);
    chk({tag, "_din"}, 64'(bram_din), 64'd0);
    chk({tag, "_we"}, 64'(bram_we), 64'd0);
    chk({tag, "_loaded"}, 64'(loaded_words), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
  endtask

  // Expected outcome is derived purely from the accepted byte stream
  task automatic verify(input string tag);
    logic [31:0] n;
    logic [35:0] e;
    int nw;
    n  = {mq[0], mq[1], mq[2], mq[3]};
    nw = (n > 32'(CAP)) ? 0 : int'(n);
    hold(4);
    chk({tag, "_nwr"}, 64'(wq.size()), 64'(nw));
    for (int i = 0; i < nw && i < wq.size(); i++) begin
      e = {4'(i), mq[4+4*i], mq[5+4*i], mq[6+4*i], mq[7+4*i]};
      chk({tag, "_wr"}, 64'(wq[i]), 64'(e));
    end
    chk({tag, "_loaded"}, 64'(loaded_words), 64'(nw));
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_err"}, 64'(err), 64'((n > 32'(CAP)) || ferr));
    if (nw > 0) chk({tag, "_donelat"}, 64'(done_cyc - last_we_cyc), 64'd1);
  endtask

  task automatic rand_load(input string tag, input int n);
    do_reset();
    send_word(32'(n));
    for (int i = 0; i < n; i++) send_word($urandom);
    verify(tag);
  endtask

  initial begin
    logic [7:0] b0, b1, b2, b3;
    rstn = 1'b0;
    mode = 3'd0;
    hold(3);
    chk_reset_vals("rst");
    rstn = 1'b1;
    hold(2);
    mode = 3'd1;

    // Two-word example load
    send_word(32'd2);
    send_word(32'hDEADBEEF);
    hold(2);
    chk("t1_mid_loaded", 64'(loaded_words), 64'd1);
    chk("t1_mid_done", 64'(done), 64'd0);
    send_word(32'h01234567);
    verify("t1");
    if (wq.size() == 2) begin
      chk("t1_w0", 64'(wq[0]), 64'({4'd0, 32'hDEADBEEF}));
      chk("t1_w1", 64'(wq[1]), 64'({4'd1, 32'h01234567}));
    end else begin
      chk("t1_wcount", 64'(wq.size()), 64'd2);
    end

    // Zero and oversize headers
    do_reset();
    send_word(32'd0);
    verify("zero");
    do_reset();
    send_word(32'h11);
    verify("over");
    do_reset();
    send_word(32'h0100_0000);
    verify("over_hi");

    // Full capacity
    rand_load("full", CAP);
    if (wq.size() == CAP) chk("full_lastaddr", 64'(wq[CAP-1][35:32]), 64'(CAP - 1));

    // Framing error inside a word, then resend
    do_reset();
    b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
    send_word(32'd1);
    send_byte(b0, 1'b1);
    send_byte(b1, 1'b1);
    send_byte(8'($urandom), 1'b0);
    chk("ferr_err", 64'(err), 64'd1);
    chk("ferr_loaded", 64'(loaded_words), 64'd0);
    send_byte(b2, 1'b1);
    send_byte(b3, 1'b1);
    verify("ferr");

    // Byte sent while in EXEC is ignored
    do_reset();
    b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
    send_word(32'd1);
    send_byte(b0, 1'b1);
    send_byte(b1, 1'b1);
    mode = 3'd2;
    send_byte(8'($urandom), 1'b1);
    chk("exec_loaded", 64'(loaded_words), 64'd0);
    chk("exec_done", 64'(done), 64'd0);
    mode = 3'd1;
    send_byte(b2, 1'b1);
    send_byte(b3, 1'b1);
    verify("exec");

    // One-cycle reset in the middle of the body
    do_reset();
    send_word(32'd2);
    send_word($urandom);
    send_byte(8'($urandom), 1'b1);
    send_byte(8'($urandom), 1'b1);
    rstn = 1'b0;
    hold(1);
    rstn = 1'b1;
    mq.delete();
    ferr = 1'b0;
    hold(1);
    chk_reset_vals("midrst");
    send_word(32'd1);
    send_word($urandom);
    verify("midrst_reload");

    for (int k = 0; k < 3; k++) rand_load("rand", $urandom_range(1, 8));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
